// File: rtl/legv8_mc_control.sv
// legv8_mc_control: multi-cycle LEGv8 control sequencer.
// Sequence: FETCH -> DECODE -> EXEC [-> MEM [-> WB]] -> FETCH.
// Unknown opcodes park the sequencer in TRAP (sticky illegal) until reset.
// Optional feature macro: LEGV8_CU_BCOND_EN decodes and evaluates B.cond.
// Without it, B.cond is an unknown opcode and traps.
// Memory handshake: mem_req is raised with mem_sel/mem_we stable and held
// until a cycle with mem_ack=1, which completes the transfer in that cycle.
// mem_ack is ignored in any state that is not requesting.
module legv8_mc_control #(
  parameter int DATA_W = 64,
  parameter int FS_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst,
  input  logic              mem_ack,
  input  logic [3:0]        flags,
  input  logic              zero,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_sel,
  output logic              ir_ld,
  output logic              pc_ld,
  output logic              pc_sel,
  output logic [4:0]        DA,
  output logic [4:0]        AA,
  output logic [4:0]        BA,
  output logic [DATA_W-1:0] const_out,
  output logic [FS_W-1:0]   FS,
  output logic              WR,
  output logic              SFL,
  output logic              En_K,
  output logic              En_ALU,
  output logic              Cin,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND, OP_ANDS, OP_ORR, OP_EOR,
    OP_LSL, OP_LSR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_CBNZ, OP_BCOND, OP_BAD
  } op_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  op_t               op;
  logic [4:0]        fs_code;
  logic [DATA_W-1:0] const_ext;
  logic              taken;
  logic              is_alu, is_k, is_mem, is_branch, is_stur, is_sub;
  logic              sets_flags, rb_from_rt, fields_on;

  // State register and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Opcode decode from the latched IR (11-bit opcode field, wildcards for
  // the shorter I/B/CB opcode formats).
  always_comb begin
    op = OP_BAD;
    casez (ir_q[31:21])
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10101011000: op = OP_ADDS;
      11'b11101011000: op = OP_SUBS;
      11'b10001010000: op = OP_AND;
      11'b11101010000: op = OP_ANDS;
      11'b10101010000: op = OP_ORR;
      11'b11001010000: op = OP_EOR;
      11'b11010011011: op = OP_LSL;
      11'b11010011010: op = OP_LSR;
      11'b1001000100?: op = OP_ADDI;
      11'b1101000100?: op = OP_SUBI;
      11'b1001001000?: op = OP_ANDI;
      11'b1011001000?: op = OP_ORRI;
      11'b1101001000?: op = OP_EORI;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      11'b000101?????: op = OP_B;
      11'b10110100???: op = OP_CBZ;
      11'b10110101???: op = OP_CBNZ;
`ifdef LEGV8_CU_BCOND_EN
      11'b01010100???: op = OP_BCOND;
`endif
      default:         op = OP_BAD;
    endcase
  end

  assign is_alu     = op inside {OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND, OP_ANDS,
                                 OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_ADDI, OP_SUBI,
                                 OP_ANDI, OP_ORRI, OP_EORI};
  assign is_k       = op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI,
                                 OP_LSL, OP_LSR};
  assign is_mem     = op inside {OP_LDUR, OP_STUR};
  assign is_stur    = (op == OP_STUR);
  assign is_branch  = op inside {OP_B, OP_CBZ, OP_CBNZ, OP_BCOND};
  assign is_sub     = op inside {OP_SUB, OP_SUBS, OP_SUBI};
  assign sets_flags = op inside {OP_ADDS, OP_SUBS, OP_ANDS};
  assign rb_from_rt = op inside {OP_STUR, OP_CBZ, OP_CBNZ};

  // ALU function select per opcode; memory ops use ADD for address calc.
  always_comb begin
    fs_code = FS_AND;
    case (op)
      OP_ADD, OP_ADDS, OP_ADDI, OP_LDUR, OP_STUR: fs_code = FS_ADD;
      OP_SUB, OP_SUBS, OP_SUBI:                   fs_code = FS_SUB;
      OP_AND, OP_ANDS, OP_ANDI:                   fs_code = FS_AND;
      OP_ORR, OP_ORRI:                            fs_code = FS_ORR;
      OP_EOR, OP_EORI:                            fs_code = FS_EOR;
      OP_LSL:                                     fs_code = FS_LSL;
      OP_LSR:                                     fs_code = FS_LSR;
      default:                                    fs_code = FS_AND;
    endcase
  end

  // Immediate extraction and extension by instruction format.
  always_comb begin
    const_ext = '0;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI:
        const_ext = DATA_W'(ir_q[21:10]);
      OP_LSL, OP_LSR:
        const_ext = DATA_W'(ir_q[15:10]);
      OP_LDUR, OP_STUR:
        const_ext = DATA_W'($signed(ir_q[20:12]));
      OP_B:
        const_ext = DATA_W'($signed({ir_q[25:0], 2'b00}));
      OP_CBZ, OP_CBNZ, OP_BCOND:
        const_ext = DATA_W'($signed({ir_q[23:5], 2'b00}));
      default:
        const_ext = '0;
    endcase
  end

  // Branch resolution; flags are {N,Z,C,V}.
  always_comb begin
    taken = 1'b0;
    case (op)
      OP_B:    taken = 1'b1;
      OP_CBZ:  taken = zero;
      OP_CBNZ: taken = ~zero;
`ifdef LEGV8_CU_BCOND_EN
      OP_BCOND: begin
        case (ir_q[3:0])
          4'h0:    taken = flags[2];
          4'h1:    taken = ~flags[2];
          4'h2:    taken = flags[1];
          4'h3:    taken = ~flags[1];
          4'h4:    taken = flags[3];
          4'h5:    taken = ~flags[3];
          4'h6:    taken = flags[0];
          4'h7:    taken = ~flags[0];
          4'h8:    taken = flags[1] & ~flags[2];
          4'h9:    taken = ~(flags[1] & ~flags[2]);
          4'hA:    taken = (flags[3] == flags[0]);
          4'hB:    taken = (flags[3] != flags[0]);
          4'hC:    taken = ~flags[2] & (flags[3] == flags[0]);
          4'hD:    taken = ~(~flags[2] & (flags[3] == flags[0]));
          default: taken = 1'b1;
        endcase
      end
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef LEGV8_CU_BCOND_EN
  logic unused_flags;
  assign unused_flags = ^flags;
`endif

  assign fields_on = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};

  // Next-state and Moore outputs; ir_ld and the STUR completion pc_ld
  // follow mem_ack within the requesting cycle.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    ir_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_sel    = 1'b0;
    DA        = '0;
    AA        = '0;
    BA        = '0;
    const_out = '0;
    FS        = '0;
    WR        = 1'b0;
    SFL       = 1'b0;
    En_K      = 1'b0;
    En_ALU    = 1'b0;
    Cin       = 1'b0;
    illegal   = 1'b0;

    if (fields_on) begin
      DA        = ir_q[4:0];
      AA        = ir_q[9:5];
      BA        = rb_from_rt ? ir_q[4:0] : ir_q[20:16];
      const_out = const_ext;
      FS        = FS_W'(fs_code);
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_ld   = 1'b1;
          ir_d    = inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (op == OP_BAD) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          En_ALU  = 1'b1;
          WR      = 1'b1;
          En_K    = is_k;
          SFL     = sets_flags;
          Cin     = is_sub;
          pc_ld   = 1'b1;
          state_d = S_FETCH;
        end else if (is_mem) begin
          En_K    = 1'b1;
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_ld   = 1'b1;
          pc_sel  = taken;
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        // Keep the address computation on the ALU while the access is pending.
        En_K    = 1'b1;
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_stur;
        if (mem_ack) begin
          pc_ld   = is_stur;
          state_d = is_stur ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        WR      = 1'b1;
        pc_ld   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_legv8_mc_control.sv
// tb_legv8_mc_control: directed + randomized instruction stream for
// legv8_mc_control. A mnemonic-level model expands each instruction into a
// per-cycle plan (mem_ack to drive, expected control word) in exp_q.
module tb_legv8_mc_control;

  localparam int DATA_W = 64;
  localparam int FS_W   = 5;

  logic              clk;
  logic              rst_n;
  logic [31:0]       inst;
  logic              mem_ack;
  logic [3:0]        flags;
  logic              zero;
  logic              mem_req, mem_we, mem_sel, ir_ld, pc_ld, pc_sel;
  logic [4:0]        DA, AA, BA;
  logic [DATA_W-1:0] const_out;
  logic [FS_W-1:0]   FS;
  logic              WR, SFL, En_K, En_ALU, Cin, illegal;

  legv8_mc_control #(.DATA_W(DATA_W), .FS_W(FS_W)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ack(mem_ack), .flags(flags),
    .zero(zero), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_sel(pc_sel), .DA(DA), .AA(AA), .BA(BA),
    .const_out(const_out), .FS(FS), .WR(WR), .SFL(SFL), .En_K(En_K),
    .En_ALU(En_ALU), .Cin(Cin), .illegal(illegal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef enum int {
    K_ADD, K_SUB, K_ADDS, K_SUBS, K_AND, K_ANDS, K_ORR, K_EOR, K_LSL, K_LSR,
    K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_EORI, K_LDUR, K_STUR, K_B, K_CBZ,
    K_CBNZ, K_BCOND, K_BAD
  } kind_t;

  // exp_q entry: [8:0] control word, [9] EXEC cycle, [10] WB cycle
  logic [10:0] exp_q[$];
  bit          ack_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  kind_t       cur_kind;
  logic [31:0] cur_inst;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t inst=%08h)", tag, obs, exp, $time, cur_inst);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] tmpl(kind_t k);
    case (k)
      K_ADD:   return 32'h8B000000;
      K_SUB:   return 32'hCB000000;
      K_ADDS:  return 32'hAB000000;
      K_SUBS:  return 32'hEB000000;
      K_AND:   return 32'h8A000000;
      K_ANDS:  return 32'hEA000000;
      K_ORR:   return 32'hAA000000;
      K_EOR:   return 32'hCA000000;
      K_LSL:   return 32'hD3600000;
      K_LSR:   return 32'hD3400000;
      K_ADDI:  return 32'h91000000;
      K_SUBI:  return 32'hD1000000;
      K_ANDI:  return 32'h92000000;
      K_ORRI:  return 32'hB2000000;
      K_EORI:  return 32'hD2000000;
      K_LDUR:  return 32'hF8400000;
      K_STUR:  return 32'hF8000000;
      K_B:     return 32'h14000000;
      K_CBZ:   return 32'hB4000000;
      K_CBNZ:  return 32'hB5000000;
      K_BCOND: return 32'h54000000;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  function automatic logic [31:0] fmask(kind_t k);
    if (k inside {K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_EORI}) return 32'hFFC00000;
    if (k inside {K_LDUR, K_STUR})                         return 32'hFFE00C00;
    if (k == K_B)                                          return 32'hFC000000;
    if (k inside {K_CBZ, K_CBNZ})                          return 32'hFF000000;
    if (k == K_BCOND)                                      return 32'hFF000010;
    if (k == K_BAD)                                        return 32'hFFFFFFFF;
    return 32'hFFE00000;
  endfunction

  function automatic bit alu_of(kind_t k);
    return k inside {K_ADD, K_SUB, K_ADDS, K_SUBS, K_AND, K_ANDS, K_ORR, K_EOR,
                     K_LSL, K_LSR, K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_EORI};
  endfunction

  function automatic bit k_of(kind_t k);
    return k inside {K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_EORI, K_LSL, K_LSR, K_LDUR, K_STUR};
  endfunction

  function automatic bit sub_of(kind_t k);
    return k inside {K_SUB, K_SUBS, K_SUBI};
  endfunction

  function automatic bit traps(kind_t k);
`ifdef LEGV8_CU_BCOND_EN
    return k == K_BAD;
`else
    return k inside {K_BAD, K_BCOND};
`endif
  endfunction

  function automatic logic [4:0] fs_of(kind_t k);
    case (k)
      K_ADD, K_ADDS, K_ADDI, K_LDUR, K_STUR: return 5'b01000;
      K_SUB, K_SUBS, K_SUBI:                 return 5'b01001;
      K_ORR, K_ORRI:                         return 5'b00100;
      K_EOR, K_EORI:                         return 5'b01100;
      K_LSL:                                 return 5'b10000;
      K_LSR:                                 return 5'b10100;
      default:                               return 5'b00000;
    endcase
  endfunction

  function automatic longint const_of(kind_t k, logic [31:0] w);
    longint v;
    if (k inside {K_ADDI, K_SUBI, K_ANDI, K_ORRI, K_EORI}) return longint'(w[21:10]);
    if (k inside {K_LSL, K_LSR})                           return longint'(w[15:10]);
    if (k inside {K_LDUR, K_STUR}) begin
      v = longint'(w[20:12]);
      if (v >= 256) v = v - 512;
      return v;
    end
    if (k == K_B) begin
      v = longint'(w[25:0]);
      if (v >= 64'd33554432) v = v - 64'd67108864;
      return v * 4;
    end
    if (k inside {K_CBZ, K_CBNZ, K_BCOND}) begin
      v = longint'(w[23:5]);
      if (v >= 262144) v = v - 524288;
      return v * 4;
    end
    return 0;
  endfunction

  function automatic bit taken_of(kind_t k, logic [31:0] w, bit z, logic [3:0] fl);
    bit n, zf, c, v;
    n = fl[3]; zf = fl[2]; c = fl[1]; v = fl[0];
    if (k == K_B)    return 1'b1;
    if (k == K_CBZ)  return z;
    if (k == K_CBNZ) return !z;
    if (k == K_BCOND) begin
      case (w[3:0])
        4'd0:  return zf;                 // EQ
        4'd1:  return !zf;                // NE
        4'd2:  return c;                  // HS
        4'd3:  return !c;                 // LO
        4'd4:  return n;                  // MI
        4'd5:  return !n;                 // PL
        4'd6:  return v;                  // VS
        4'd7:  return !v;                 // VC
        4'd8:  return c && !zf;           // HI
        4'd9:  return !(c && !zf);        // LS
        4'd10: return n == v;             // GE
        4'd11: return n != v;             // LT
        4'd12: return !zf && (n == v);    // GT
        4'd13: return zf || (n != v);     // LE
        default: return 1'b1;             // always
      endcase
    end
    return 1'b0;
  endfunction

  function automatic logic [8:0] cw(bit req, bit sel, bit we, bit irld, bit pcld,
                                    bit pcsel, bit wr, bit sfl, bit ill);
    return {ill, sfl, wr, pcsel, pcld, irld, we, sel, req};
  endfunction

  function automatic logic [8:0] obs_ctrl();
    return {illegal, SFL, WR, pc_sel, pc_ld, ir_ld, mem_we, mem_sel, mem_req};
  endfunction

  task automatic push(input bit a, input logic [8:0] c, input bit ex, input bit wb);
    ack_q.push_back(a);
    exp_q.push_back({wb, ex, c});
  endtask

  // Expand one instruction into its per-cycle plan.
  task automatic model_instr(input kind_t k, input logic [31:0] w, input int fw,
                             input int mw, input bit z, input logic [3:0] fl);
    bit st;
    st = (k == K_STUR);
    for (int i = 0; i < fw; i++) push(1'b0, cw(1,0,0,0,0,0,0,0,0), 0, 0);
    push(1'b1, cw(1,0,0,1,0,0,0,0,0), 0, 0);
    push(1'($urandom_range(0,1)), 9'd0, 0, 0);                       // DECODE
    if (traps(k)) begin
      for (int i = 0; i < 3; i++) push(1'($urandom_range(0,1)), cw(0,0,0,0,0,0,0,0,1), 0, 0);
      return;
    end
    if (alu_of(k)) begin
      push(1'($urandom_range(0,1)),
           cw(0,0,0,0,1,0,1, k inside {K_ADDS, K_SUBS, K_ANDS}, 0), 1, 0);
    end else if (k inside {K_B, K_CBZ, K_CBNZ, K_BCOND}) begin
      push(1'($urandom_range(0,1)), cw(0,0,0,0,1, taken_of(k, w, z, fl), 0,0,0), 1, 0);
    end else begin
      push(1'($urandom_range(0,1)), 9'd0, 1, 0);                     // EXEC
      for (int i = 0; i < mw; i++) push(1'b0, cw(1,1,st,0,0,0,0,0,0), 0, 0);
      push(1'b1, cw(1,1,st,0,st,0,0,0,0), 0, 0);
      if (!st) push(1'($urandom_range(0,1)), cw(0,0,0,0,1,0,1,0,0), 0, 1);
    end
  endtask

  // ---------------- driver / checker ----------------
  // Called at posedge+1; each cycle drives inputs, compares at negedge.
  task automatic run_plan(input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      logic [10:0] e;
      bit          a;
      string       nm;
      e  = exp_q.pop_front();
      a  = ack_q.pop_front();
      nm = cur_kind.name();
      mem_ack = a;
      inst    = (a && e[3]) ? cur_inst : $urandom();
      @(negedge clk);
      check({nm, "/ctrl"}, obs_ctrl(), e[8:0]);
      if (e[9]) begin
        check({nm, "/DA"}, DA, cur_inst[4:0]);
        check({nm, "/AA"}, AA, cur_inst[9:5]);
        check({nm, "/BA"}, BA, (cur_kind inside {K_STUR, K_CBZ, K_CBNZ}) ?
                               cur_inst[4:0] : cur_inst[20:16]);
        check({nm, "/FS"}, FS, fs_of(cur_kind));
        check({nm, "/const"}, const_out, const_of(cur_kind, cur_inst));
        check({nm, "/EnK"}, En_K, k_of(cur_kind));
        check({nm, "/EnALU"}, En_ALU, alu_of(cur_kind));
        check({nm, "/Cin"}, Cin, sub_of(cur_kind));
      end
      if (e[10]) check({nm, "/WB_DA"}, DA, cur_inst[4:0]);
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("rst_illegal", illegal, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_wr", WR, 0);
    check("rst_pc_ld", pc_ld, 0);
    check("rst_ir_ld", ir_ld, 0);
    check("rst_fields", {DA, FS, const_out[15:0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input kind_t k, input logic [31:0] w, input int fw,
                           input int mw, input bit z, input logic [3:0] fl);
    cur_kind = k;
    cur_inst = w;
    zero     = z;
    flags    = fl;
    model_instr(k, w, fw, mw, z, fl);
    run_plan(10000);
    if (traps(k)) do_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; inst = '0; flags = '0; zero = 1'b0;
    cur_kind = K_BAD; cur_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // directed
    run_instr(K_ADD,   32'h8B020023, 0, 0, 1'b0, 4'h0);   // ADD X3,X1,X2
    run_instr(K_SUBI,  32'hD1001CA5, 0, 0, 1'b0, 4'h0);   // SUBI X5,X5,#7
    run_instr(K_SUBS,  32'hEB0600A5, 1, 0, 1'b0, 4'h0);   // SUBS X5,X5,X6
    run_instr(K_LDUR,  32'hF85F8049, 0, 2, 1'b0, 4'h0);   // LDUR X9,[X2,#-8]
    run_instr(K_CBZ,   32'hB4000084, 0, 0, 1'b1, 4'h0);   // CBZ X4,+16 taken
    run_instr(K_CBZ,   32'hB4000084, 0, 0, 1'b0, 4'h0);   // not taken
    run_instr(K_STUR,  32'hF8010067, 2, 1, 1'b0, 4'h0);   // STUR X7,[X3,#16]
    run_instr(K_BCOND, 32'h54000101, 0, 0, 1'b0, 4'h4);   // B.NE with Z=1
    run_instr(K_BAD,   32'hFFFFFFFF, 0, 0, 1'b0, 4'h0);

    // randomized stream
    for (int i = 0; i < 150; i++) begin
      kind_t       k;
      logic [31:0] w;
      k = kind_t'($urandom_range(0, 21));
      w = (tmpl(k) & fmask(k)) | ($urandom() & ~fmask(k));
      run_instr(k, w, $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // reset during the MEM phase of a STUR
    cur_kind = K_STUR;
    cur_inst = 32'hF8010067;
    model_instr(K_STUR, cur_inst, 0, 5, 1'b0, 4'h0);
    run_plan(5);
    exp_q.delete();
    ack_q.delete();
    mem_ack = 1'b0;
    #1;
    check("mid_stur_we", mem_we, 1);
    check("mid_stur_sel", mem_sel, 1);
    do_reset();
    run_instr(K_ADD, 32'h8B020023, 1, 0, 1'b0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
